mc_batch_pricer: RTL
====================

# mc_batch_pricer

Parametrised Monte Carlo option-pricing aggregator.
- Accepts a stream of simulated terminal asset prices over a valid/ready handshake.
- Deals the samples round-robin across `NUM_LANES` payoff/accumulate lanes.
- After a fixed batch of `2^LOG_BATCH` samples, reduces the lanes and emits the floor-averaged payoff as the option price.
- Sits between the path generator and the result register bank.
- Supersedes the fixed four-core, call-only pricer with configurable width, lane count, batch size, a call/put mode and a proper start/done protocol.

## Interface

Parameters:
- `DATA_W`, 12: width of path, strike and price.
- `NUM_LANES`, 4: number of accumulation lanes. Must be a power of 2, ≥ 1.
- `LOG_BATCH`, 10: log2 of the samples per estimate. Must satisfy `LOG_BATCH ≥ log2(NUM_LANES)`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin a batch. Honoured only in IDLE.
- `K`  in  `DATA_W`  strike, unsigned. Latched on an accepted start.
- `put_mode`  in  1  0 = call, 1 = put. Latched on an accepted start.
- `in_valid`  in  1  `path` is valid.
- `in_ready`  out  1  block accepts a sample. High exactly in RUN.
- `path`  in  `DATA_W`  terminal asset price, unsigned.
- `busy`  out  1  high in every state except IDLE.
- `price`  out  `DATA_W`  last estimate. Held until the next DONE or reset.
- `valid`  out  1  one-cycle pulse when `price` updates.

## Operation

States:
- **IDLE**: waits for `start`. On `start`:
  - latch `K` and `put_mode`;
  - clear all lane accumulators, the sample counter `cnt` (`LOG_BATCH` bits) and the lane pointer;
  - go to RUN.
- **RUN**: `in_ready` = 1.
  - On each handshake (`in_valid && in_ready` at a rising edge), register `path` into the stage-1 slot tagged with the current lane, advance the lane pointer modulo `NUM_LANES`, and increment `cnt`.
  - The handshake with `cnt` = all-ones is the last one: go to DRAIN, with `cnt` wrapping to 0.
- **DRAIN** (1 cycle): the final stage-2 accumulate completes. Go to REDUCE with reduce index 0 and `sum` = 0.
- **REDUCE** (`NUM_LANES` cycles): each cycle, `sum += acc[idx]` and `idx++`.
  - On the last lane, go to DONE.
  - On that same edge, `price <= (sum + acc[NUM_LANES-1]) >> LOG_BATCH`.
- **DONE** (1 cycle): `valid` = 1. Next edge goes to IDLE.

Payoff pipeline:
- Stage 2 computes the payoff from the stage-1 register:
  - call: `path > K ? path - K : 0`;
  - put: `K > path ? K - path : 0`.
- The payoff is added to the tagged lane's accumulator one edge after the handshake.
- `path == K` gives payoff 0.

Width rules:
- Payoff: `DATA_W` bits.
- Lane accumulator: `DATA_W + LOG_BATCH - log2(NUM_LANES)` bits.
- `sum`: `DATA_W + LOG_BATCH` bits.
- Overflow is impossible by construction. No saturation logic.
- Division is a truncating right shift (floor).

Boundary conditions:
- `in_valid` while `in_ready` = 0 (IDLE, DRAIN, REDUCE, DONE): ignored, no state change.
- Gaps in `in_valid` during RUN: stall with no effect. Only handshakes count.
- `start` outside IDLE: ignored. `K` and `put_mode` changes after latching: ignored until the next batch.
- Lane pointer and `cnt` wrap silently. Every lane receives exactly `2^LOG_BATCH / NUM_LANES` samples.
- `NUM_LANES` = 1: REDUCE lasts 1 cycle.

Reset (asserted at any time, including mid-batch):
- Immediately forces IDLE.
- Clears `cnt`, the accumulators, `sum`, the stage-1 slot and the latched `K` and mode.
- Outputs go to `price` = 0, `valid` = 0, `in_ready` = 0, `busy` = 0.
- No partial result is ever emitted.

## Timing

- Reset values: `price` = 0, `valid` = 0, `in_ready` = 0, `busy` = 0.
- `start` sampled at edge S: `in_ready` and `busy` go high in the cycle after S.
- First sample can be accepted at edge S+1.
- Peak throughput: 1 sample/cycle.
- Last handshake at edge E0:
  - DRAIN in cycle after E0;
  - REDUCE cycles after E1 … E(NUM_LANES);
  - `price` updates and `valid` is high in the cycle after edge E(NUM_LANES+1).
  - That is `NUM_LANES+1` edges of latency (5 for the default).
- `busy` drops the cycle after DONE. A new `start` is accepted from that cycle.
- Minimum batch period: `2^LOG_BATCH + NUM_LANES + 3` cycles.

## Test plan

Configuration for scenarios 1–5: `DATA_W`=12, `NUM_LANES`=4, `LOG_BATCH`=4 (16 samples).

1. Call, `K`=1000, 16 × `path`=1500, back-to-back → `price`=500; `valid` pulses once, 5 cycles after the last handshake.
2. Put, `K`=2000, `path` alternating 1000/3000 → sum 8000 → `price`=500. Repeat in call mode → `price`=500 (payoff 1000 on each 3000).
3. Call, `K`=0, 16 × `path`=4095 → `price`=4095, no overflow. Then 15 × payoff 0 plus 1 × payoff 15 → `price`=0 (floor); with 31 instead → `price`=1.
4. Random `in_valid` gaps, `in_valid` held high during IDLE/REDUCE/DONE, and `start` pulsed mid-RUN → only 16 handshakes counted, result identical to the gap-free run, latched `K` unchanged.
5. Assert `rst_n` low after 7 handshakes → all outputs 0, `busy`=0 during reset. Next full batch (scenario 1 stimulus) → `price`=500, no residue from the aborted batch.
6. `NUM_LANES`=1, `LOG_BATCH`=2, call, `K`=10, paths 10/20/30/40 → payoffs 0/10/20/30 → `price`=15; `valid` 2 edges after the last handshake.

Source files
------------

// File: rtl/mc_batch_pricer.sv
// Monte Carlo option-pricing aggregator: deals payoffs round-robin over NUM_LANES
// accumulators, then reduces the lanes and emits the floor-averaged batch payoff.
module mc_batch_pricer #(
  parameter int DATA_W    = 12,
  parameter int NUM_LANES = 4,
  parameter int LOG_BATCH = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] K,
  input  logic              put_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] path,
  output logic              busy,
  output logic [DATA_W-1:0] price,
  output logic              valid
);

  localparam int LOG_LANES = $clog2(NUM_LANES);
  localparam int LANE_W    = (NUM_LANES > 1) ? LOG_LANES : 1;
  localparam int ACC_W     = DATA_W + LOG_BATCH - LOG_LANES;
  localparam int SUM_W     = DATA_W + LOG_BATCH;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_REDUCE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   k_q;
  logic                put_q;
  logic [LOG_BATCH-1:0] cnt_q;
  logic [LANE_W-1:0]   lane_q;
  logic                s1_valid_q;
  logic [DATA_W-1:0]   s1_path_q;
  logic [LANE_W-1:0]   s1_lane_q;
  logic [ACC_W-1:0]    acc_q [NUM_LANES];
  logic [SUM_W-1:0]    sum_q;
  logic [LANE_W-1:0]   idx_q;
  logic [DATA_W-1:0]   price_q;

  logic                start_accept;
  logic                handshake;
  logic [DATA_W-1:0]   payoff;
  logic [ACC_W-1:0]    acc_sel;
  logic [SUM_W-1:0]    sum_next;

  assign in_ready     = (state_q == S_RUN);
  assign busy         = (state_q != S_IDLE);
  assign valid        = (state_q == S_DONE);
  assign price        = price_q;
  assign start_accept = (state_q == S_IDLE) && start;
  assign handshake    = in_valid && in_ready;
  assign sum_next     = sum_q + SUM_W'(acc_sel);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_RUN;
      S_RUN:    if (handshake && (&cnt_q)) state_d = S_DRAIN;
      S_DRAIN:  state_d = S_REDUCE;
      S_REDUCE: if (idx_q == LAST_LANE) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Stage-2 payoff; an at-the-money sample pays nothing in either mode.
  always_comb begin
    payoff = '0;
    if (put_q) begin
      if (k_q > s1_path_q) payoff = k_q - s1_path_q;
    end else if (s1_path_q > k_q) begin
      payoff = s1_path_q - k_q;
    end
  end

  always_comb begin
    acc_sel = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (idx_q == LANE_W'(i)) acc_sel = acc_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q        <= '0;
      put_q      <= 1'b0;
      cnt_q      <= '0;
      lane_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_path_q  <= '0;
      s1_lane_q  <= '0;
      sum_q      <= '0;
      idx_q      <= '0;
      price_q    <= '0;
      // NOTE: the lane accumulators are a handful of flops, so reset clears them like any register.
      for (int i = 0; i < NUM_LANES; i++) acc_q[i] <= '0;
    end else begin
      s1_valid_q <= handshake;

      if (start_accept) begin
        k_q    <= K;
        put_q  <= put_mode;
        cnt_q  <= '0;
        lane_q <= '0;
      end else if (handshake) begin
        s1_path_q <= path;
        s1_lane_q <= lane_q;
        lane_q    <= (lane_q == LAST_LANE) ? '0 : lane_q + 1'b1;
        cnt_q     <= cnt_q + 1'b1;
      end

      for (int i = 0; i < NUM_LANES; i++) begin
        if (start_accept) begin
          acc_q[i] <= '0;
        end else if (s1_valid_q && (s1_lane_q == LANE_W'(i))) begin
          acc_q[i] <= acc_q[i] + ACC_W'(payoff);
        end
      end

      if (state_q == S_DRAIN) begin
        idx_q <= '0;
        sum_q <= '0;
      end else if (state_q == S_REDUCE) begin
        sum_q <= sum_next;
        idx_q <= idx_q + 1'b1;
        if (idx_q == LAST_LANE) price_q <= DATA_W'(sum_next >> LOG_BATCH);
      end
    end
  end

endmodule
